// File: rtl/ft60x_defs_pkg.sv
// ft60x_defs_pkg: shared definitions for the FT60x Tx arbiter and its Rx-side companion.
// Holds the arbiter state encoding, the default frame tags, and the header/trailer field layout.
package ft60x_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_TRL  = 2'd3
  } arb_state_t;

  localparam int NUM_CH = 4;

  localparam logic [7:0] HDR_MAGIC_DEF = 8'hA5;
  localparam logic [7:0] TRL_MAGIC_DEF = 8'h5A;

  // Field positions shared by header and trailer words
  localparam int MAGIC_LSB     = 24;
  localparam int HDR_CHAN_LSB  = 0;
  localparam int TRL_FLAG_BIT  = 17;
  localparam int TRL_COUNT_LSB = 0;

  // Header: tag in the top byte, channel number in the bottom two bits, zeros elsewhere
  function automatic logic [31:0] make_header(input logic [7:0] magic, input logic [1:0] chan);
    logic [31:0] w;
    w = '0;
    w[MAGIC_LSB +: 8]    = magic;
    w[HDR_CHAN_LSB +: 2] = chan;
    return w;
  endfunction

  // Trailer: tag, end-of-packet flag, and the number of data words carried by the burst
  function automatic logic [31:0] make_trailer(input logic [7:0] magic, input logic flag,
                                               input logic [15:0] count);
    logic [31:0] w;
    w = '0;
    w[MAGIC_LSB +: 8]      = magic;
    w[TRL_FLAG_BIT]        = flag;
    w[TRL_COUNT_LSB +: 16] = count;
    return w;
  endfunction

endpackage

// File: rtl/ft60x_rr_arb.sv
// ft60x_rr_arb: combinational round-robin picker over four requesters.
// The search starts one past the previous winner, so the previous winner has lowest priority.
module ft60x_rr_arb
  import ft60x_defs_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant,
  output logic       any
);

  logic [1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest requester overrides the rest
  always_comb begin
    grant = last_grant;
    idx   = '0;
    any   = |req;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/ft60x_tx_arb.sv
// ft60x_tx_arb: shares the FT60x Tx FIFO inport between four packet sources.
// A grant is held until the packet ends or the burst limit is hit; every burst is
// framed by a header naming the channel and a trailer carrying flag and word count.
module ft60x_tx_arb
  import ft60x_defs_pkg::*;
#(
  parameter int         MAX_BURST = 256,
  parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEF,
  parameter logic [7:0] TRL_MAGIC = TRL_MAGIC_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [3:0]   req_valid_i,
  input  logic [127:0] req_data_i,
  input  logic [3:0]   req_last_i,
  output logic [3:0]   req_accept_o,
  output logic         outport_valid_o,
  output logic [31:0]  outport_data_o,
  input  logic         outport_accept_i
);

  localparam logic [15:0] BURST_LIMIT = 16'(MAX_BURST);

  arb_state_t  state;
  logic [1:0]  grant_q;
  logic [1:0]  last_grant;
  logic [15:0] count_q;
  logic        last_flag_q;

  logic [1:0]  pick;
  logic        pick_any;
  logic        slot_free;
  logic        gnt_valid;
  logic        gnt_last;
  logic [31:0] gnt_data;

  ft60x_rr_arb u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant),
    .grant      (pick),
    .any        (pick_any)
  );

  // The output register can take a new word when empty or when its word leaves this cycle
  assign slot_free = !outport_valid_o || outport_accept_i;

  // Select the granted channel's request signals
  always_comb begin
    gnt_valid = req_valid_i[grant_q];
    gnt_last  = req_last_i[grant_q];
    gnt_data  = req_data_i[{grant_q, 5'b0} +: 32];
  end

  // Only the granted channel sees accept, and only while its data can enter the output register
  always_comb begin
    req_accept_o = '0;
    if (state == ST_DATA) begin
      req_accept_o[grant_q] = slot_free;
    end
  end

  // Arbitration, framing and output register sequencing
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state           <= ST_IDLE;
      grant_q         <= '0;
      last_grant      <= 2'd3;
      count_q         <= '0;
      last_flag_q     <= 1'b0;
      outport_valid_o <= 1'b0;
      outport_data_o  <= '0;
    end else begin
      if (outport_accept_i) begin
        outport_valid_o <= 1'b0;
        outport_data_o  <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick;
            state   <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (slot_free) begin
            outport_valid_o <= 1'b1;
            outport_data_o  <= make_header(HDR_MAGIC, grant_q);
            count_q         <= '0;
            state           <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (slot_free && gnt_valid) begin
            outport_valid_o <= 1'b1;
            outport_data_o  <= gnt_data;
            count_q         <= count_q + 16'd1;
            if (gnt_last || ((count_q + 16'd1) == BURST_LIMIT)) begin
              last_flag_q <= gnt_last;
              state       <= ST_TRL;
            end
          end
        end

        ST_TRL: begin
          if (slot_free) begin
            outport_valid_o <= 1'b1;
            outport_data_o  <= make_trailer(TRL_MAGIC, last_flag_q, count_q);
            last_grant      <= grant_q;
            state           <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
